// File: rtl/vga_text_pkg.sv
// Shared types and constants for the VGA text-mode Avalon writer.
//   state_e      : writer FSM states
//   cur_op_e     : operations the cursor sub-module can perform
//   TEXT_COLS/ROWS, VRAM_WORDS, PAL_BASE : text-buffer geometry and palette address
//   DEFAULT_PAL  : 8 palette words, two 12-bit RGB entries each (CGA colours)
package vga_text_pkg;

   typedef enum logic [1:0] {
      ST_INIT_PAL = 2'd0,
      ST_CLEAR    = 2'd1,
      ST_IDLE     = 2'd2,
      ST_CHAR_WR  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      CUR_HOLD = 3'd0,
      CUR_ADV  = 3'd1,
      CUR_NL   = 3'd2,
      CUR_CR   = 3'd3,
      CUR_ZERO = 3'd4
   } cur_op_e;

   localparam int          TEXT_COLS   = 80;
   localparam int          TEXT_ROWS   = 30;
   localparam int          VRAM_WORDS  = 1200;
   localparam int          PAL_WORDS   = 8;
   localparam logic [11:0] PAL_BASE    = 12'h800;
   localparam logic [11:0] CURSOR_LAST = 12'(TEXT_COLS * TEXT_ROWS - 1);

   localparam logic [7:0]  CHAR_NL = 8'h0A;
   localparam logic [7:0]  CHAR_CR = 8'h0D;

   // Word n = {7'b0, rgb[2n+1], rgb[2n], 1'b0}; rgb is 4 bits per channel.
   localparam logic [7:0][31:0] DEFAULT_PAL = {
      32'h01FF_FFEA,   // 15 FFF | 14 FF5
      32'h01EB_FEAA,   // 13 F5F | 12 F55
      32'h00BF_EBEA,   // 11 5FF | 10 5F5
      32'h00AB_EAAA,   //  9 55F |  8 555
      32'h0155_54A0,   //  7 AAA |  6 A50
      32'h0141_5400,   //  5 A0A |  4 A00
      32'h0015_4140,   //  3 0AA |  2 0A0
      32'h0001_4000    //  1 00A |  0 000
   };

   function automatic logic [31:0] clear_word(input logic [7:0] attr);
      return {8'h00, attr, 8'h00, attr};
   endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Cursor position tracker for the 80x30 text screen.
//   clk, reset_n : clock, async active-low reset
//   op           : HOLD / ADV (next cell, wraps 2399->0) / NL (next row start,
//                  row 29 -> row 0) / CR (column 0) / ZERO
//   cursor       : linear cell index row*80+col
module vga_text_cursor
   import vga_text_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  cur_op_e     op,
   output logic [11:0] cursor
);

   logic [11:0] cursor_q, cursor_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [4:0]  row_next;

   // Row and column are tracked alongside the linear index so that
   // NL and CR need only subtract/add, never multiply.
   always_comb begin
      row_next = (row_q == 5'(TEXT_ROWS - 1)) ? 5'd0 : row_q + 5'd1;
      cursor_d = cursor_q;
      col_d    = col_q;
      row_d    = row_q;
      case (op)
         CUR_ADV: begin
            if (col_q == 7'(TEXT_COLS - 1)) begin
               col_d = 7'd0;
               row_d = row_next;
            end else begin
               col_d = col_q + 7'd1;
            end
            cursor_d = (cursor_q == CURSOR_LAST) ? 12'd0 : cursor_q + 12'd1;
         end
         CUR_NL: begin
            col_d    = 7'd0;
            row_d    = row_next;
            cursor_d = (row_q == 5'(TEXT_ROWS - 1)) ? 12'd0
                     : cursor_q - {5'd0, col_q} + 12'(TEXT_COLS);
         end
         CUR_CR: begin
            col_d    = 7'd0;
            cursor_d = cursor_q - {5'd0, col_q};
         end
         CUR_ZERO: begin
            col_d    = 7'd0;
            row_d    = 5'd0;
            cursor_d = 12'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cursor_q <= 12'd0;
         col_q    <= 7'd0;
         row_q    <= 5'd0;
      end else begin
         cursor_q <= cursor_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

   assign cursor = cursor_q;

endmodule

// File: rtl/vga_text_avl_writer.sv
// Character-stream to Avalon-MM writer for a VGA text-mode slave.
// Loads the default palette, clears the screen, then writes one 16-bit
// {char, attr} cell per accepted character; handles NL/CR and clear requests.
//   clk, reset_n                 : clock, async active-low reset
//   char_valid/data/attr/ready   : character stream (valid/ready handshake)
//   clear_req, clear_attr        : clear-screen request and fill attribute
//   busy, cursor                 : status
//   avm_*                        : Avalon-MM write-only master
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_INIT_PAL | writing 8 palette words to 0x800..0x807
// ST_CLEAR    | filling VRAM words 0..1199 with clear_attr
// ST_IDLE     | ready for a character, or starting a pending clear
// ST_CHAR_WR  | one cell write in flight
module vga_text_avl_writer
   import vga_text_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   input  logic [7:0]  char_attr,
   output logic        char_ready,
   input  logic        clear_req,
   input  logic [7:0]  clear_attr,
   output logic        busy,
   output logic [11:0] cursor,
   output logic        avm_cs,
   output logic        avm_write,
   output logic [11:0] avm_addr,
   output logic [3:0]  avm_byte_en,
   output logic [31:0] avm_writedata,
   input  logic        avm_waitrequest
);

   state_e      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic        clr_pend_q, clr_pend_d;
   logic        avm_write_q, avm_write_d;
   logic [11:0] avm_addr_q, avm_addr_d;
   logic [3:0]  avm_be_q, avm_be_d;
   logic [31:0] avm_wdata_q, avm_wdata_d;
   cur_op_e     cur_op;
   logic        done;
   logic [2:0]  pal_idx;

   vga_text_cursor u_cursor (
      .clk     (clk),
      .reset_n (reset_n),
      .op      (cur_op),
      .cursor  (cursor)
   );

   // Bus outputs are registered: the next transfer is loaded on the edge
   // that completes the current one, so fills run back to back and the
   // request is inherently held stable while waitrequest is high.
   always_comb begin
      done        = avm_write_q & ~avm_waitrequest;
      pal_idx     = avm_addr_q[2:0] + 3'd1;
      state_d     = state_q;
      cnt_d       = cnt_q;
      clr_pend_d  = clr_pend_q | clear_req;
      avm_write_d = avm_write_q;
      avm_addr_d  = avm_addr_q;
      avm_be_d    = avm_be_q;
      avm_wdata_d = avm_wdata_q;
      cur_op      = CUR_HOLD;
      case (state_q)
         ST_INIT_PAL: begin
            if (!avm_write_q) begin
               avm_write_d = 1'b1;
               avm_addr_d  = PAL_BASE;
               avm_be_d    = 4'hF;
               avm_wdata_d = DEFAULT_PAL[0];
               cnt_d       = 11'(PAL_WORDS - 1);
            end else if (done) begin
               if (cnt_q == 11'd0) begin
                  // clear_attr is captured here, once, for the whole fill
                  state_d     = ST_CLEAR;
                  cnt_d       = 11'(VRAM_WORDS - 1);
                  avm_addr_d  = 12'd0;
                  avm_wdata_d = clear_word(clear_attr);
               end else begin
                  cnt_d       = cnt_q - 11'd1;
                  avm_addr_d  = avm_addr_q + 12'd1;
                  avm_wdata_d = DEFAULT_PAL[pal_idx];
               end
            end
         end
         ST_CLEAR: begin
            if (done) begin
               if (cnt_q == 11'd0) begin
                  state_d     = ST_IDLE;
                  avm_write_d = 1'b0;
                  avm_addr_d  = 12'd0;
                  avm_be_d    = 4'h0;
                  avm_wdata_d = 32'd0;
                  cur_op      = CUR_ZERO;
               end else begin
                  cnt_d      = cnt_q - 11'd1;
                  avm_addr_d = avm_addr_q + 12'd1;
               end
            end
         end
         ST_IDLE: begin
            if (clr_pend_q) begin
               // requests arriving this cycle merge into the clear now starting
               state_d     = ST_CLEAR;
               clr_pend_d  = 1'b0;
               cnt_d       = 11'(VRAM_WORDS - 1);
               avm_write_d = 1'b1;
               avm_addr_d  = 12'd0;
               avm_be_d    = 4'hF;
               avm_wdata_d = clear_word(clear_attr);
            end else if (char_valid) begin
               case (char_data)
                  CHAR_NL: cur_op = CUR_NL;
                  CHAR_CR: cur_op = CUR_CR;
                  default: begin
                     state_d     = ST_CHAR_WR;
                     avm_write_d = 1'b1;
                     avm_addr_d  = {1'b0, cursor[11:1]};
                     if (cursor[0]) begin
                        avm_be_d    = 4'b1100;
                        avm_wdata_d = {char_data, char_attr, 16'h0000};
                     end else begin
                        avm_be_d    = 4'b0011;
                        avm_wdata_d = {16'h0000, char_data, char_attr};
                     end
                  end
               endcase
            end
         end
         ST_CHAR_WR: begin
            if (done) begin
               state_d     = ST_IDLE;
               avm_write_d = 1'b0;
               avm_addr_d  = 12'd0;
               avm_be_d    = 4'h0;
               avm_wdata_d = 32'd0;
               cur_op      = CUR_ADV;
            end
         end
         default: state_d = ST_INIT_PAL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_INIT_PAL;
         cnt_q       <= 11'd0;
         clr_pend_q  <= 1'b0;
         avm_write_q <= 1'b0;
         avm_addr_q  <= 12'd0;
         avm_be_q    <= 4'h0;
         avm_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         clr_pend_q  <= clr_pend_d;
         avm_write_q <= avm_write_d;
         avm_addr_q  <= avm_addr_d;
         avm_be_q    <= avm_be_d;
         avm_wdata_q <= avm_wdata_d;
      end
   end

   assign char_ready    = (state_q == ST_IDLE) && !clr_pend_q;
   assign busy          = (state_q != ST_IDLE);
   assign avm_cs        = avm_write_q;
   assign avm_write     = avm_write_q;
   assign avm_addr      = avm_addr_q;
   assign avm_byte_en   = avm_be_q;
   assign avm_writedata = avm_wdata_q;

endmodule
